bus_requester: RTL and testbench

Requester-side front end for the two-port arbiter: one instance drives each `req_x`/`gnt_x` pair. It accepts a burst command over a valid/ready handshake, raises the request, waits for the grant with a bounded timeout, issues one data beat per granted cycle until the burst is complete, then drops the request for one cycle so the arbiter can re-arbitrate. Completion and timeout are reported as single-cycle pulses to the command source.

---
 rtl/bus_req_pkg.sv | 15 +
 rtl/req_timer.sv | 36 +++
 rtl/bus_requester.sv | 115 +++++++++++
 tb/tb_bus_requester.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bus_req_pkg.sv
// Shared types and defaults for the arbiter requester front end.
package bus_req_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } state_t;

  localparam int LEN_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 15;
  localparam int TMR_W       = 8;

endpackage

// File: rtl/req_timer.sv
// Saturating wait counter: counts enabled cycles up to LIMIT and flags the
// cycle whose increment reaches LIMIT (and every cycle after that).
module req_timer
  import bus_req_pkg::*;
#(
  parameter int CNT_W = TMR_W,
  parameter int LIMIT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] MAX  = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count_r;

  // Wait counter with clear priority over enable, holding at LIMIT.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (en && (count_r != MAX)) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r >= LAST);

endmodule

// File: rtl/bus_requester.sv
// Requester front end: accepts a burst command, requests the bus, issues one
// beat per granted cycle, then releases the request for one cycle.
module bus_requester
  import bus_req_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             req,
  input  logic             gnt,
  output logic             beat_valid,
  output logic [LEN_W-1:0] beat_idx,
  output logic             done,
  output logic             timeout
);

  state_t           state_r;
  logic [LEN_W-1:0] remaining_r;
  logic [LEN_W-1:0] beat_idx_r;
  logic             req_r;
  logic             cmd_ready_r;
  logic             done_r;
  logic             timeout_r;
  logic             accept_s;
  logic             wait_en_s;
  logic             expired_s;

  assign accept_s  = (state_r == IDLE) && cmd_valid;
  assign wait_en_s = (state_r == REQ) && !gnt;

  req_timer #(
    .CNT_W (TMR_W),
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (accept_s),
    .en      (wait_en_s),
    .expired (expired_s)
  );

  // Burst FSM; req/cmd_ready are loaded with the value for the next state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= IDLE;
      remaining_r <= {LEN_W{1'b0}};
      beat_idx_r  <= {LEN_W{1'b0}};
      req_r       <= 1'b0;
      cmd_ready_r <= 1'b1;
      done_r      <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            state_r     <= REQ;
            remaining_r <= cmd_len;
            beat_idx_r  <= {LEN_W{1'b0}};
            req_r       <= 1'b1;
            cmd_ready_r <= 1'b0;
          end
        end
        REQ: begin
          // A grant on the final waiting cycle beats the timeout.
          if (gnt) begin
            state_r <= XFER;
          end else if (expired_s) begin
            state_r     <= IDLE;
            req_r       <= 1'b0;
            cmd_ready_r <= 1'b1;
            timeout_r   <= 1'b1;
          end
        end
        XFER: begin
          if (gnt) begin
            if (remaining_r == {LEN_W{1'b0}}) begin
              state_r <= REL;
              req_r   <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              beat_idx_r  <= beat_idx_r + LEN_W'(1);
              remaining_r <= remaining_r - LEN_W'(1);
            end
          end
        end
        REL: begin
          state_r     <= IDLE;
          cmd_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          remaining_r <= {LEN_W{1'b0}};
          beat_idx_r  <= {LEN_W{1'b0}};
          req_r       <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign beat_valid = (state_r == XFER) && gnt;
  assign beat_idx   = beat_idx_r;
  assign req        = req_r;
  assign cmd_ready  = cmd_ready_r;
  assign done       = done_r;
  assign timeout    = timeout_r;

endmodule

// File: tb/tb_bus_requester.sv
// Randomized bench for bus_requester: each burst's expected trace is derived
// from its grant pattern (first grant, counted beats) relative to acceptance.
module tb_bus_requester;

  localparam int LW   = 4;
  localparam int TO   = 15;
  localparam int MAXC = 128;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          gnt = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_ready, req, beat_valid, done, timeout;
  logic [LW-1:0] beat_idx;

  int n_checks = 0;
  int n_pass   = 0;
  int prev_idx = 0;

  always #5 clock = ~clock;

  bus_requester #(.LEN_W(LW), .TIMEOUT(TO)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .req        (req),
    .gnt        (gnt),
    .beat_valid (beat_valid),
    .beat_idx   (beat_idx),
    .done       (done),
    .timeout    (timeout)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_cycle(input string where, input int e_rdy, input int e_req,
                             input int e_bv, input int e_idx, input int e_done, input int e_to);
    @(negedge clock);
    check({where, " cmd_ready"}, int'(cmd_ready), e_rdy);
    check({where, " req"}, int'(req), e_req);
    check({where, " beat_valid"}, int'(beat_valid), e_bv);
    check({where, " beat_idx"}, int'(beat_idx), e_idx);
    check({where, " done"}, int'(done), e_done);
    check({where, " timeout"}, int'(timeout), e_to);
  endtask

  // mode: 0 random, 1 never granted, 2 grant from last wait cycle,
  //       3 grant one cycle after req, 4 grant with a 2-cycle stall after beat 0
  task automatic run_burst(input int len, input int mode, input int id);
    bit g[MAXC];
    int e_req[MAXC], e_rdy[MAXC], e_bv[MAXC], e_idx[MAXC], e_done[MAXC], e_to[MAXC];
    int first = -1;
    int last = -1;
    int e_end;
    int beats = 0;
    int d = $urandom_range(1, 20);
    for (int t = 0; t < MAXC; t++) begin
      case (mode)
        0:       g[t] = (t >= d) && ((t >= 60) || ($urandom_range(0, 9) < 7));
        1:       g[t] = 1'b0;
        2:       g[t] = (t >= TO);
        3:       g[t] = (t >= 2);
        default: g[t] = ((t >= 1) && (t <= 2)) || (t >= 5);
      endcase
      e_req[t] = 0; e_rdy[t] = 0; e_bv[t] = 0; e_idx[t] = 0; e_done[t] = 0; e_to[t] = 0;
    end
    for (int t = 1; t <= TO; t++) begin
      if (g[t] && first < 0) first = t;
    end
    e_rdy[0] = 1;
    e_idx[0] = prev_idx;
    if (first < 0) begin
      e_end = TO + 1;
      for (int t = 1; t <= TO; t++) e_req[t] = 1;
      e_to[e_end] = 1;
      prev_idx = 0;
    end else begin
      for (int t = first + 1; t < MAXC - 2; t++) begin
        e_idx[t] = beats;
        if (g[t]) begin
          e_bv[t] = 1;
          beats++;
          if (beats == len + 1) begin
            last = t;
            break;
          end
        end
      end
      e_end = last + 2;
      for (int t = 1; t <= last; t++) e_req[t] = 1;
      e_done[last + 1] = 1;
      e_idx[last + 1] = len;
      e_idx[e_end] = len;
      prev_idx = len;
    end
    e_rdy[e_end] = 1;
    for (int t = 0; t <= e_end; t++) begin
      if (t == 0) begin
        cmd_valid = 1'b1;
        cmd_len = LW'(len);
        gnt = 1'($urandom_range(0, 1));
      end else if (t == e_end) begin
        cmd_valid = 1'b0;
        cmd_len = LW'($urandom_range(0, 15));
        gnt = 1'($urandom_range(0, 1));
      end else begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_len = LW'($urandom_range(0, 15));
        gnt = g[t];
      end
      check_cycle($sformatf("b%0d t%0d", id, t), e_rdy[t], e_req[t], e_bv[t],
                  e_idx[t], e_done[t], e_to[t]);
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    gnt = 1'b1;
    cmd_valid = 1'b1;
    tick();
    tick();
    check_cycle("reset", 1, 0, 0, 0, 0, 0);
    reset = 1'b1;
    gnt = 1'b0;
    cmd_valid = 1'b0;
    tick();

    run_burst(3, 3, 0);
    run_burst(2, 4, 1);
    run_burst(0, 1, 2);
    run_burst(5, 2, 3);
    run_burst(15, 3, 4);
    run_burst(0, 3, 5);

    // Reset in the middle of a 4-beat burst, right after beat 1.
    cmd_valid = 1'b1;
    cmd_len = LW'(3);
    gnt = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check_cycle("midrst beat1", 0, 1, 1, 1, 0, 0);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_cycle("midrst after", 1, 0, 0, 0, 0, 0);
    tick();
    prev_idx = 0;

    for (int i = 0; i < 60; i++) begin
      run_burst($urandom_range(0, 15), 0, 100 + i);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
